// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hold/squash/bubble sequencing for the 5-stage core
// Optional stall cycle counter built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
   parameter logic [5:0] LOAD_OP   = 6'd16,
   parameter logic [5:0] HALT_OP   = 6'h3F,
   parameter int unsigned BR_SHADOW = 2,
   parameter int unsigned DRAIN_CYC = 3
) (
   input  logic        clk,
   input  logic        rstd,
   input  logic        id_valid,
   input  logic [5:0]  id_op,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_jmp,
   input  logic        ex_valid,
   input  logic [5:0]  ex_op,
   input  logic [4:0]  ex_rd,
   output logic        stall_f,
   output logic        kill_f,
   output logic        stall_d,
   output logic        bubble_e,
   output logic        pc_load,
   output logic        halted,
   output logic [31:0] stall_cnt
);

   localparam logic [1:0] RUN     = 2'd0;
   localparam logic [1:0] BR_WAIT = 2'd1;
   localparam logic [1:0] DRAIN   = 2'd2;
   localparam logic [1:0] HALTED  = 2'd3;

   localparam logic [2:0] BR_INIT    = 3'(BR_SHADOW);
   localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYC);

   logic [1:0] state, nxt_state;
   logic [2:0] cnt, nxt_cnt;
   logic       load_use;
   logic       is_branch;

   assign load_use = ex_valid && id_valid && (ex_op == LOAD_OP) && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   always_comb begin
      is_branch = 1'b0;
      case (id_op)
         6'd32, 6'd33, 6'd34, 6'd35, 6'd42: is_branch = 1'b1;
         default:                           is_branch = 1'b0;
      endcase
   end

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      stall_f   = 1'b0;
      kill_f    = 1'b0;
      stall_d   = 1'b0;
      bubble_e  = 1'b0;
      pc_load   = 1'b0;
      halted    = 1'b0;
      case (state)
         RUN: begin
            // A pending load-use hazard masks any control-flow op in decode.
            if (load_use) begin
               stall_f  = 1'b1;
               stall_d  = 1'b1;
               bubble_e = 1'b1;
            end else if (id_valid && (id_op == HALT_OP)) begin
               stall_f   = 1'b1;
               kill_f    = 1'b1;
               nxt_state = DRAIN;
               nxt_cnt   = DRAIN_INIT;
            end else if (id_valid && is_branch) begin
               stall_f   = 1'b1;
               kill_f    = 1'b1;
               nxt_state = BR_WAIT;
               nxt_cnt   = BR_INIT;
            end else if (id_valid && id_jmp) begin
               kill_f = 1'b1;
            end
         end
         BR_WAIT: begin
            stall_f = 1'b1;
            kill_f  = 1'b1;
            if (cnt > 3'd1) begin
               nxt_cnt = cnt - 3'd1;
            end else begin
               pc_load   = 1'b1;
               nxt_state = RUN;
               nxt_cnt   = 3'd0;
            end
         end
         DRAIN: begin
            stall_f = 1'b1;
            kill_f  = 1'b1;
            nxt_cnt = cnt - 3'd1;
            if (cnt <= 3'd1) begin
               nxt_state = HALTED;
               nxt_cnt   = 3'd0;
            end
         end
         default: begin
            stall_f = 1'b1;
            kill_f  = 1'b1;
            halted  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_cnt;

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         perf_cnt <= 32'd0;
      end else if (stall_f && (state != HALTED) && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign stall_cnt = perf_cnt;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rstd = 1'b0;
   logic        id_valid = 1'b0;
   logic [5:0]  id_op = '0;
   logic [4:0]  id_rs = '0;
   logic [4:0]  id_rt = '0;
   logic        id_uses_rt = 1'b0;
   logic        id_jmp = 1'b0;
   logic        ex_valid = 1'b0;
   logic [5:0]  ex_op = '0;
   logic [4:0]  ex_rd = '0;
   logic        stall_f, kill_f, stall_d, bubble_e, pc_load, halted;
   logic [31:0] stall_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          pc_pulses = 0;
   logic [31:0] model_cnt = 0;
   logic [5:0]  exp_q[$];

   hazard_ctrl dut (
      .clk(clk), .rstd(rstd),
      .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .id_jmp(id_jmp),
      .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd),
      .stall_f(stall_f), .kill_f(kill_f), .stall_d(stall_d), .bubble_e(bubble_e),
      .pc_load(pc_load), .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (pc_load) pc_pulses++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
`ifdef HAZARD_PERF_EN
      return model_cnt;
`else
      return 32'd0;
`endif
   endfunction

   // Outputs packed as {stall_f, kill_f, stall_d, bubble_e, pc_load, halted}.
   task automatic drive_cmp(input string tag, input logic iv, input logic [5:0] iop,
                            input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                            input logic jmp, input logic ev, input logic [5:0] eop,
                            input logic [4:0] erd, input logic [5:0] e);
      logic [5:0] exp;
      @(negedge clk);
      id_valid = iv; id_op = iop; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_jmp = jmp;
      ex_valid = ev; ex_op = eop; ex_rd = erd;
      exp_q.push_back(e);
      #2;
      exp = exp_q.pop_front();
      check(tag, {26'd0, stall_f, kill_f, stall_d, bubble_e, pc_load, halted}, {26'd0, exp});
      check({tag, "_cnt"}, stall_cnt, exp_cnt());
   endtask

   task automatic cyc(input string tag, input logic iv, input logic [5:0] iop,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic jmp, input logic ev, input logic [5:0] eop,
                      input logic [4:0] erd, input logic [5:0] e);
      drive_cmp(tag, iv, iop, rs, rt, urt, jmp, ev, eop, erd, e);
      @(posedge clk);
      #1;
      if (e[5] && !e[0] && model_cnt != 32'hFFFF_FFFF) model_cnt++;
   endtask

   task automatic idle(input string tag, input logic [5:0] e);
      cyc(tag, 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 6'd0, 5'd0, e);
   endtask

   initial begin
      #2;
      check("reset_out", {26'd0, stall_f, kill_f, stall_d, bubble_e, pc_load, halted}, 32'd0);
      check("reset_cnt", stall_cnt, 32'd0);
      @(negedge clk);
      rstd = 1'b1;

      idle("idle", 6'b000000);

      // load-use on rs, then the load has moved on
      cyc("lu_rs",    1, 6'd0, 5'd5, 5'd0, 0, 0, 1, 6'd16, 5'd5, 6'b101100);
      cyc("lu_clear", 1, 6'd0, 5'd5, 5'd0, 0, 0, 0, 6'd0,  5'd0, 6'b000000);
      cyc("lu_rd0",   1, 6'd0, 5'd0, 5'd0, 0, 0, 1, 6'd16, 5'd0, 6'b000000);
      cyc("lu_norm",  1, 6'd0, 5'd5, 5'd0, 0, 0, 1, 6'd8,  5'd5, 6'b000000);
      cyc("lu_rt_nu", 1, 6'd0, 5'd1, 5'd6, 0, 0, 1, 6'd16, 5'd6, 6'b000000);
      cyc("lu_idinv", 0, 6'd0, 5'd5, 5'd0, 0, 0, 1, 6'd16, 5'd5, 6'b000000);

      // branch, BR_SHADOW=2
      cyc("br_t0", 1, 6'd32, 5'd1, 5'd2, 1, 0, 0, 6'd0, 5'd0, 6'b110000);
      idle("br_t1", 6'b110000);
      idle("br_t2", 6'b110010);
      idle("br_t3", 6'b000000);

      // load-use on rt holds the branch one cycle
      cyc("lub_t0", 1, 6'd33, 5'd1, 5'd7, 1, 0, 1, 6'd16, 5'd7, 6'b101100);
      cyc("lub_t1", 1, 6'd33, 5'd1, 5'd7, 1, 0, 0, 6'd0,  5'd0, 6'b110000);
      idle("lub_t2", 6'b110000);
      idle("lub_t3", 6'b110010);
      idle("lub_t4", 6'b000000);

      // direct jump
      cyc("jmp",      1, 6'd2, 5'd0, 5'd0, 0, 1, 0, 6'd0, 5'd0, 6'b010000);
      idle("jmp_next", 6'b000000);

      // async reset with branch wait counter at 2
      cyc("rbr_t0", 1, 6'd34, 5'd0, 5'd0, 0, 0, 0, 6'd0, 5'd0, 6'b110000);
      drive_cmp("rbr_t1", 0, 6'd0, 5'd0, 5'd0, 0, 0, 0, 6'd0, 5'd0, 6'b110000);
      #1 rstd = 1'b0;
      model_cnt = 0;
      #1;
      check("rst_async_out", {26'd0, stall_f, kill_f, stall_d, bubble_e, pc_load, halted}, 32'd0);
      check("rst_async_cnt", stall_cnt, 32'd0);
      @(posedge clk);
      #1;
      check("rst_hold_out", {26'd0, stall_f, kill_f, stall_d, bubble_e, pc_load, halted}, 32'd0);
      @(negedge clk);
      rstd = 1'b1;
      idle("rst_after", 6'b000000);
      idle("rst_after2", 6'b000000);

      // halt, DRAIN_CYC=3
      cyc("halt_t0", 1, 6'h3F, 5'd0, 5'd0, 0, 0, 0, 6'd0, 5'd0, 6'b110000);
      idle("halt_t1", 6'b110000);
      idle("halt_t2", 6'b110000);
      idle("halt_t3", 6'b110000);
      idle("halt_t4", 6'b110001);
      cyc("halt_br", 1, 6'd32, 5'd0, 5'd0, 0, 0, 0, 6'd0, 5'd0, 6'b110001);
      idle("halt_br1", 6'b110001);
      idle("halt_br2", 6'b110001);
      cyc("halt_lu", 1, 6'd0, 5'd5, 5'd0, 0, 0, 1, 6'd16, 5'd5, 6'b110001);
      cyc("halt_jmp", 1, 6'd2, 5'd0, 5'd0, 0, 1, 0, 6'd0, 5'd0, 6'b110001);

      check("pc_load_pulses", pc_pulses, 32'd2);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
